// File: rtl/scb_pkg.sv
// rtl/scb_pkg.sv - shared constants, unit ids and latency table for the issue scoreboard
package scb_pkg;

  localparam int SCB_CNT_W = 4;
  localparam int SCB_AW    = 7;

  typedef enum logic [2:0] {
    UID_SIMPLE = 3'd0,
    UID_SHIFT  = 3'd1,
    UID_FLOAT  = 3'd2,
    UID_PERM   = 3'd3,
    UID_LS     = 3'd4,
    UID_DP     = 3'd5,
    UID_BR     = 3'd6,
    UID_DIV    = 3'd7
  } uid_e;

  // Result latency of each execution unit, in cycles, indexed by uid.
  function automatic logic [SCB_CNT_W-1:0] lat_of(input logic [2:0] uid);
    logic [SCB_CNT_W-1:0] lat;
    case (uid_e'(uid))
      UID_SIMPLE: lat = 4'd2;
      UID_SHIFT:  lat = 4'd4;
      UID_FLOAT:  lat = 4'd6;
      UID_PERM:   lat = 4'd4;
      UID_LS:     lat = 4'd4;
      UID_DP:     lat = 4'd6;
      UID_BR:     lat = 4'd2;
      default:    lat = 4'd7;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/scb_reg_cnt.sv
// rtl/scb_reg_cnt.sv - countdown counter for one architectural register
module scb_reg_cnt
  import scb_pkg::*;
#(
  parameter int CNT_W = SCB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load_e,
  input  logic [CNT_W-1:0] val_e,
  input  logic             load_o,
  input  logic [CNT_W-1:0] val_o,
  output logic [CNT_W-1:0] cnt,
  output logic             ready
);

  logic [CNT_W-1:0] nxt;

  // Decrement toward zero; a new writer can only extend the wait, never shorten it.
  always_comb begin
    nxt = (cnt == '0) ? '0 : cnt - 1'b1;
    if (load_e && (val_e > nxt)) nxt = val_e;
    if (load_o && (val_o > nxt)) nxt = val_o;
  end

  // Counter state; flush frees the register on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (flush) cnt <= '0;
    else            cnt <= nxt;
  end

  assign ready = (cnt == '0);

endmodule

// File: rtl/ff_issue_scoreboard.sv
// rtl/ff_issue_scoreboard.sv - dual-slot issue hazard scoreboard; SPU_SCB_FWD_EN selects forwarding load values
module ff_issue_scoreboard
  import scb_pkg::*;
#(
  parameter int NREG     = 128,
  parameter int CNT_W    = SCB_CNT_W,
  parameter int WB_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ie_valid,
  input  logic [6:0]  ie_rtaddr,
  input  logic        ie_wreg,
  input  logic [2:0]  ie_uid,
  input  logic [20:0] ie_src,
  input  logic [2:0]  ie_src_use,
  input  logic        io_valid,
  input  logic [6:0]  io_rtaddr,
  input  logic        io_wreg,
  input  logic [2:0]  io_uid,
  input  logic [20:0] io_src,
  input  logic [2:0]  io_src_use,
  output logic        ie_ack,
  output logic        io_ack,
  output logic        scb_busy,
  output logic [31:0] scb_stall_cnt
);

  logic [NREG-1:0]  ready;
  logic [CNT_W-1:0] val_e;
  logic [CNT_W-1:0] val_o;
  logic             e_ok;
  logic             o_ok;
  logic             o_pair_raw;
  logic             stall;

  // Load value: time until a dependent may issue after this write.
`ifdef SPU_SCB_FWD_EN
  assign val_e = lat_of(ie_uid);
  assign val_o = lat_of(io_uid);
`else
  assign val_e = lat_of(ie_uid) + CNT_W'(WB_DELAY);
  assign val_o = lat_of(io_uid) + CNT_W'(WB_DELAY);
`endif

  // Source readiness and issue ordering; the odd slot never passes the even slot.
  always_comb begin
    e_ok       = 1'b1;
    o_ok       = 1'b1;
    o_pair_raw = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (ie_src_use[k] && !ready[ie_src[k*7 +: 7]]) e_ok = 1'b0;
      if (io_src_use[k] && !ready[io_src[k*7 +: 7]]) o_ok = 1'b0;
      if (io_src_use[k] && (io_src[k*7 +: 7] == ie_rtaddr)) o_pair_raw = 1'b1;
    end
    ie_ack = ie_valid & e_ok & ~flush;
    io_ack = io_valid & o_ok & ~(o_pair_raw & ie_ack & ie_wreg) & ~flush & (ie_ack | ~ie_valid);
  end

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    logic [CNT_W-1:0] cnt;
    scb_reg_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .load_e (ie_ack & ie_wreg & (ie_rtaddr == 7'(r))),
      .val_e  (val_e),
      .load_o (io_ack & io_wreg & (io_rtaddr == 7'(r))),
      .val_o  (val_o),
      .cnt    (cnt),
      .ready  (ready[r])
    );
  end

  assign scb_busy = ~&ready;
  assign stall    = (ie_valid & ~ie_ack) | (io_valid & ~io_ack);

  // Saturating count of cycles where a presented instruction was held back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      scb_stall_cnt <= '0;
    else if (!flush && stall && (scb_stall_cnt != 32'hFFFF_FFFF))
      scb_stall_cnt <= scb_stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_ff_issue_scoreboard.sv
// tb/tb_ff_issue_scoreboard.sv - self-checking bench for ff_issue_scoreboard
module tb_ff_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ie_valid = 1'b0, io_valid = 1'b0;
  logic [6:0]  ie_rtaddr = '0, io_rtaddr = '0;
  logic        ie_wreg = 1'b0, io_wreg = 1'b0;
  logic [2:0]  ie_uid = '0, io_uid = '0;
  logic [20:0] ie_src = '0, io_src = '0;
  logic [2:0]  ie_src_use = '0, io_src_use = '0;
  logic        ie_ack, io_ack, scb_busy;
  logic [31:0] scb_stall_cnt;

  ff_issue_scoreboard dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ie_valid(ie_valid), .ie_rtaddr(ie_rtaddr), .ie_wreg(ie_wreg), .ie_uid(ie_uid),
    .ie_src(ie_src), .ie_src_use(ie_src_use),
    .io_valid(io_valid), .io_rtaddr(io_rtaddr), .io_wreg(io_wreg), .io_uid(io_uid),
    .io_src(io_src), .io_src_use(io_src_use),
    .ie_ack(ie_ack), .io_ack(io_ack), .scb_busy(scb_busy), .scb_stall_cnt(scb_stall_cnt)
  );

  always #5 clk = ~clk;

  localparam int LAT_TAB [8] = '{2, 4, 6, 4, 4, 6, 2, 7};
`ifdef SPU_SCB_FWD_EN
  localparam int WBD = 0;
`else
  localparam int WBD = 2;
`endif

  int          n_cmp = 0;
  int          n_fail = 0;
  int          mcnt [128];
  logic [31:0] mstall;
  bit          m_ie_ack, m_io_ack;

  function automatic int lv(input int uid);
    return LAT_TAB[uid] + WBD;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit srcs_ready(input logic [20:0] src, input logic [2:0] use_bits);
    for (int k = 0; k < 3; k++)
      if (use_bits[k] && mcnt[src[k*7 +: 7]] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit srcs_hit(input logic [20:0] src, input logic [2:0] use_bits, input logic [6:0] a);
    for (int k = 0; k < 3; k++)
      if (use_bits[k] && src[k*7 +: 7] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    for (int r = 0; r < 128; r++) if (mcnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_eval();
    m_ie_ack = ie_valid && srcs_ready(ie_src, ie_src_use) && !flush;
    m_io_ack = io_valid && srcs_ready(io_src, io_src_use) && !flush && (m_ie_ack || !ie_valid)
               && !(m_ie_ack && ie_wreg && srcs_hit(io_src, io_src_use, ie_rtaddr));
  endtask

  task automatic model_reset();
    for (int r = 0; r < 128; r++) mcnt[r] = 0;
    mstall = '0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    model_eval();
    if (flush) begin
      for (int r = 0; r < 128; r++) mcnt[r] = 0;
    end else begin
      if (((ie_valid && !m_ie_ack) || (io_valid && !m_io_ack)) && mstall != 32'hFFFF_FFFF)
        mstall = mstall + 1;
      for (int r = 0; r < 128; r++) mcnt[r] = imax(mcnt[r] - 1, 0);
      if (m_ie_ack && ie_wreg) mcnt[ie_rtaddr] = imax(mcnt[ie_rtaddr], lv(ie_uid));
      if (m_io_ack && io_wreg) mcnt[io_rtaddr] = imax(mcnt[io_rtaddr], lv(io_uid));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0;
    ie_valid = 0; ie_rtaddr = '0; ie_wreg = 0; ie_uid = '0; ie_src = '0; ie_src_use = '0;
    io_valid = 0; io_rtaddr = '0; io_wreg = 0; io_uid = '0; io_src = '0; io_src_use = '0;
  endtask

  task automatic drain();
    clear_inputs();
    for (int i = 0; i < 16; i++) cycle();
  endtask

  task automatic test_reset();
    rst = 1;
    ie_valid = 1; ie_wreg = 1; ie_rtaddr = 7'd0;
    io_valid = 1; io_src = '0; io_src_use = 3'b001;
    @(negedge clk);
    n_cmp++; if (scb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", scb_busy); end
    n_cmp++; if (scb_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", scb_stall_cnt); end
    n_cmp++; if (ie_ack !== 1'b1) begin n_fail++; $display("FAIL reset_ie_ack got %0b want 1", ie_ack); end
    n_cmp++; if (io_ack !== 1'b0) begin n_fail++; $display("FAIL reset_pair_raw got %0b want 0", io_ack); end
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    clear_inputs();
  endtask

  task automatic measure_stall(input logic [6:0] r, output int stalls, output bit acked);
    clear_inputs();
    ie_valid = 1; ie_src = {r, 7'd0, 7'd0}; ie_src_use = 3'b100;
    stalls = 0; acked = 0;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(negedge clk);
      if (ie_ack === 1'b1) acked = 1; else stalls++;
      cycle();
    end
  endtask

  task automatic test_raw_latency();
    int stalls; bit acked;
    clear_inputs();
    ie_valid = 1; ie_wreg = 1; ie_rtaddr = 7'd5; ie_uid = 3'd2;
    @(negedge clk);
    n_cmp++; if (ie_ack !== 1'b1) begin n_fail++; $display("FAIL raw_producer_ack got %0b want 1", ie_ack); end
    cycle();
    measure_stall(7'd5, stalls, acked);
    n_cmp++; if (!acked) begin n_fail++; $display("FAIL raw_timeout got no ack want ack within 20 cycles"); end
    n_cmp++; if (stalls != lv(2)) begin n_fail++; $display("FAIL raw_stalls got %0d want %0d", stalls, lv(2)); end
    drain();
  endtask

  task automatic test_intra_pair();
    clear_inputs();
    ie_valid = 1; ie_wreg = 1; ie_rtaddr = 7'd9; ie_uid = 3'd0;
    io_valid = 1; io_src = {7'd9, 7'd0, 7'd0}; io_src_use = 3'b100;
    @(negedge clk);
    n_cmp++; if (ie_ack !== 1'b1) begin n_fail++; $display("FAIL pair_ie_ack got %0b want 1", ie_ack); end
    n_cmp++; if (io_ack !== 1'b0) begin n_fail++; $display("FAIL pair_io_ack got %0b want 0", io_ack); end
    cycle();
    ie_valid = 0; ie_wreg = 0;
    @(negedge clk);
    n_cmp++; if (io_ack !== 1'b0) begin n_fail++; $display("FAIL pair_next_io_ack got %0b want 0", io_ack); end
    cycle();
    drain();
  endtask

  task automatic test_in_order();
    clear_inputs();
    ie_valid = 1; ie_wreg = 1; ie_rtaddr = 7'd3; ie_uid = 3'd7;
    cycle();
    clear_inputs();
    ie_valid = 1; ie_src = {7'd3, 7'd0, 7'd0}; ie_src_use = 3'b100;
    io_valid = 1; io_wreg = 1; io_rtaddr = 7'd20; io_uid = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (io_ack !== 1'b0) begin n_fail++; $display("FAIL inorder_io_ack got %0b want 0", io_ack); end
      n_cmp++; if (scb_stall_cnt !== mstall) begin n_fail++; $display("FAIL inorder_stall_cnt got %0d want %0d", scb_stall_cnt, mstall); end
      cycle();
    end
    @(negedge clk);
    n_cmp++; if (scb_stall_cnt !== mstall) begin n_fail++; $display("FAIL inorder_stall_after got %0d want %0d", scb_stall_cnt, mstall); end
    drain();
  endtask

  task automatic test_waw();
    int stalls; bit acked; int want;
    clear_inputs();
    ie_valid = 1; ie_wreg = 1; ie_rtaddr = 7'd7; ie_uid = 3'd7;
    cycle();
    ie_uid = 3'd0;
    cycle();
    want = imax(lv(7) - 1, lv(0));
    measure_stall(7'd7, stalls, acked);
    n_cmp++; if (!acked || stalls != want) begin n_fail++; $display("FAIL waw_stalls got %0d (acked %0b) want %0d", stalls, acked, want); end
    drain();
  endtask

  task automatic test_flush();
    clear_inputs();
    ie_valid = 1; ie_wreg = 1; ie_rtaddr = 7'd1; ie_uid = 3'd1;
    io_valid = 1; io_wreg = 1; io_rtaddr = 7'd2; io_uid = 3'd3;
    cycle();
    ie_rtaddr = 7'd3; ie_uid = 3'd5; io_rtaddr = 7'd4; io_uid = 3'd6;
    cycle();
    clear_inputs();
    flush = 1;
    ie_valid = 1; ie_src = {7'd1, 7'd0, 7'd0}; ie_src_use = 3'b100;
    io_valid = 1; io_src = {7'd0, 7'd4, 7'd0}; io_src_use = 3'b010;
    @(negedge clk);
    n_cmp++; if (ie_ack !== 1'b0 || io_ack !== 1'b0) begin n_fail++; $display("FAIL flush_acks got %0b%0b want 00", ie_ack, io_ack); end
    n_cmp++; if (scb_busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before got %0b want 1", scb_busy); end
    cycle();
    flush = 0;
    @(negedge clk);
    n_cmp++; if (scb_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after got %0b want 0", scb_busy); end
    n_cmp++; if (ie_ack !== 1'b1 || io_ack !== 1'b1) begin n_fail++; $display("FAIL flush_acks_after got %0b%0b want 11", ie_ack, io_ack); end
    n_cmp++; if (scb_stall_cnt !== mstall) begin n_fail++; $display("FAIL flush_stall_cnt got %0d want %0d", scb_stall_cnt, mstall); end
    cycle();
    drain();
  endtask

  task automatic test_rst_mid();
    clear_inputs();
    ie_valid = 1; ie_wreg = 1; ie_rtaddr = 7'd6; ie_uid = 3'd7;
    cycle();
    clear_inputs();
    @(negedge clk);
    rst = 1;
    #1;
    n_cmp++; if (scb_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %0b want 0", scb_busy); end
    n_cmp++; if (scb_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rstmid_stall got %0d want 0", scb_stall_cnt); end
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      flush = ($urandom_range(29) == 0);
      ie_valid = ($urandom_range(4) != 0); io_valid = ($urandom_range(4) != 0);
      ie_wreg = $urandom_range(1); io_wreg = $urandom_range(1);
      ie_rtaddr = 7'($urandom_range(7)); io_rtaddr = 7'($urandom_range(7));
      ie_uid = 3'($urandom_range(7)); io_uid = 3'($urandom_range(7));
      ie_src = {7'($urandom_range(7)), 7'($urandom_range(7)), 7'($urandom_range(7))};
      io_src = {7'($urandom_range(7)), 7'($urandom_range(7)), 7'($urandom_range(7))};
      ie_src_use = 3'($urandom_range(7)); io_src_use = 3'($urandom_range(7));
      @(negedge clk);
      model_eval();
      n_cmp++; if (ie_ack !== m_ie_ack) begin n_fail++; $display("FAIL rnd_ie_ack cyc %0d got %0b want %0b", i, ie_ack, m_ie_ack); end
      n_cmp++; if (io_ack !== m_io_ack) begin n_fail++; $display("FAIL rnd_io_ack cyc %0d got %0b want %0b", i, io_ack, m_io_ack); end
      n_cmp++; if (scb_busy !== m_busy()) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %0b want %0b", i, scb_busy, m_busy()); end
      n_cmp++; if (scb_stall_cnt !== mstall) begin n_fail++; $display("FAIL rnd_stall cyc %0d got %0d want %0d", i, scb_stall_cnt, mstall); end
      cycle();
    end
    drain();
  endtask

  initial begin
    model_reset();
    clear_inputs();
    @(posedge clk); #1;
    test_reset();
    test_raw_latency();
    test_intra_pair();
    test_in_order();
    test_waw();
    test_flush();
    test_random();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
